mc_controller: RTL and testbench

Multicycle control unit for the RISC-V datapath: a Moore state machine that sequences each instruction over 3–5 cycles and drives all datapath enables and mux selects. It sits directly upstream of the ALU decoder and supplies its `ALUOp`. It also generates `ImmSrc` and the final `PCWrite`. The supported instruction classes are lw, sw, R-type, I-type ALU, beq and jal.

---
 rtl/mc_controller.sv | 173 +++++++++++++++++
 tb/tb_mc_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore sequencer driving the datapath enables and mux selects.
// Optional build macro MEM_WAIT_EN makes FETCH, MEMREAD and MEMWRITE wait on mem_ready.
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       AdrSrc,
   output logic [1:0] ImmSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       illegal_op
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
   } state_t;

   typedef struct packed {
      logic [1:0] aluOp;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] resultSrc;
      logic       adrSrc;
      logic       irWrite;
      logic       pcUpdate;
      logic       branch;
      logic       regWrite;
      logic       memWrite;
      logic       isFetch;
      logic       isDecode;
   } ctl_t;

   state_t state;
   state_t nextState;
   ctl_t   ctl;
   logic   ready;
   logic   legalOp;
   logic   fetchStall;

`ifdef MEM_WAIT_EN
   assign ready = mem_ready;
`else
   logic unusedMemReady;
   assign unusedMemReady = mem_ready;
   assign ready = 1'b1;
`endif

   // Control word for each state; registered so outputs come straight from flops.
   function automatic ctl_t decodeState(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.irWrite = 1'b1; c.aluSrcB = 2'b10; c.resultSrc = 2'b10;
            c.pcUpdate = 1'b1; c.isFetch = 1'b1;
         end
         DECODE: begin
            c.aluSrcA = 2'b01; c.aluSrcB = 2'b01; c.isDecode = 1'b1;
         end
         MEMADR: begin
            c.aluSrcA = 2'b10; c.aluSrcB = 2'b01;
         end
         MEMREAD: c.adrSrc = 1'b1;
         MEMWB: begin
            c.resultSrc = 2'b01; c.regWrite = 1'b1;
         end
         MEMWRITE: begin
            c.adrSrc = 1'b1; c.memWrite = 1'b1;
         end
         EXECUTER: begin
            c.aluSrcA = 2'b10; c.aluOp = 2'b10;
         end
         EXECUTEI: begin
            c.aluSrcA = 2'b10; c.aluSrcB = 2'b01; c.aluOp = 2'b10;
         end
         ALUWB: c.regWrite = 1'b1;
         BEQ: begin
            c.aluSrcA = 2'b10; c.aluOp = 2'b01; c.branch = 1'b1;
         end
         JAL: begin
            c.aluSrcA = 2'b01; c.aluSrcB = 2'b10; c.pcUpdate = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      legalOp = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: legalOp = 1'b1;
         default: legalOp = 1'b0;
      endcase
   end

   // Sequencing: every state advances in one cycle unless it is waiting on memory.
   always_comb begin
      nextState = FETCH;
      case (state)
         FETCH:    nextState = ready ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: nextState = MEMADR;
               OP_R:         nextState = EXECUTER;
               OP_I:         nextState = EXECUTEI;
               OP_BEQ:       nextState = BEQ;
               OP_JAL:       nextState = JAL;
               default:      nextState = FETCH;
            endcase
         end
         MEMADR:   nextState = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  nextState = ready ? MEMWB : MEMREAD;
         MEMWB:    nextState = FETCH;
         MEMWRITE: nextState = ready ? FETCH : MEMWRITE;
         EXECUTER: nextState = ALUWB;
         EXECUTEI: nextState = ALUWB;
         ALUWB:    nextState = FETCH;
         BEQ:      nextState = FETCH;
         JAL:      nextState = ALUWB;
         default:  nextState = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         ctl   <= decodeState(FETCH);
      end else begin
         state <= nextState;
         ctl   <= decodeState(nextState);
      end
   end

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // Write enables are masked while reset is high so an aborted instruction commits nothing.
   assign fetchStall = ctl.isFetch & ~ready;
   assign ALUOp      = ctl.aluOp;
   assign ALUSrcA    = ctl.aluSrcA;
   assign ALUSrcB    = ctl.aluSrcB;
   assign ResultSrc  = ctl.resultSrc;
   assign AdrSrc     = ctl.adrSrc;
   assign IRWrite    = ctl.irWrite & ~fetchStall & ~reset;
   assign PCWrite    = ((ctl.pcUpdate & ~fetchStall) | (ctl.branch & Zero)) & ~reset;
   assign RegWrite   = ctl.regWrite & ~reset;
   assign MemWrite   = ctl.memWrite & ~reset;
   assign illegal_op = ctl.isDecode & ~legalOp & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: per-cycle expected output vectors go through a scoreboard queue.
// Define MEM_WAIT_EN to also exercise the memory wait-state behaviour.
module tb_mc_controller;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                  S_MEMWRITE = 5, S_EXECUTER = 6, S_EXECUTEI = 7, S_ALUWB = 8,
                  S_BEQ = 9, S_JAL = 10;

`ifdef MEM_WAIT_EN
   localparam logic RDY = 1'b1;
`else
   localparam logic RDY = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic       Zero;
   logic       mem_ready;
   logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op;

   int errors = 0;
   int checks = 0;
   logic [15:0] expQ[$];
   string       lblQ[$];

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
      .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .AdrSrc(AdrSrc), .ImmSrc(ImmSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal_op(illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [15:0] observed = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ImmSrc,
                           IRWrite, PCWrite, RegWrite, MemWrite, illegal_op};

   // Reference outputs for one cycle, written directly from the state table.
   function automatic logic [15:0] expectedOutputs(input int st, input logic [6:0] opv,
                                                   input logic zero, input logic rdy,
                                                   input logic rst);
      logic [1:0] aop = 2'b00, sa = 2'b00, sb = 2'b00, rs = 2'b00, imm = 2'b00;
      logic adr = 0, irw = 0, pcu = 0, br = 0, rw = 0, mw = 0, ill = 0, pcw = 0;
      case (opv)
         7'b0100011: imm = 2'b01;
         7'b1100011: imm = 2'b10;
         7'b1101111: imm = 2'b11;
         default:    imm = 2'b00;
      endcase
      case (st)
         S_FETCH:    begin irw = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
         S_DECODE:   begin
            sa = 2'b01; sb = 2'b01;
            ill = !(opv inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111});
         end
         S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
         S_MEMREAD:  adr = 1;
         S_MEMWB:    begin rs = 2'b01; rw = 1; end
         S_MEMWRITE: begin adr = 1; mw = 1; end
         S_EXECUTER: begin sa = 2'b10; aop = 2'b10; end
         S_EXECUTEI: begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         S_ALUWB:    rw = 1;
         S_BEQ:      begin sa = 2'b10; aop = 2'b01; br = 1; end
         S_JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1; end
         default:    ;
      endcase
`ifdef MEM_WAIT_EN
      if (st == S_FETCH) begin irw = irw & rdy; pcu = pcu & rdy; end
`else
      if (rdy) ;
`endif
      pcw = pcu | (br & zero);
      if (rst) begin irw = 0; pcw = 0; rw = 0; mw = 0; ill = 0; end
      return {aop, sa, sb, rs, adr, imm, irw, pcw, rw, mw, ill};
   endfunction

   // One clock: drive inputs, queue the expectation, compare at the falling edge.
   task automatic cycle(input int st, input logic rst, input logic zero, input logic rdy,
                        input string lbl);
      logic [15:0] exp;
      string       name;
      reset     = rst;
      Zero      = zero;
      mem_ready = rdy;
      expQ.push_back(expectedOutputs(st, op, zero, rdy, rst));
      lblQ.push_back(lbl);
      @(negedge clk);
      exp  = expQ.pop_front();
      name = lblQ.pop_front();
      checks++;
      if (observed !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (ALUOp,SrcA,SrcB,ResSrc,Adr,Imm,IRW,PCW,RegW,MemW,ill)",
                  name, observed, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      op = 7'b0110011;
      for (int i = 0; i < 3; i++) cycle(S_FETCH, 1, 0, RDY, $sformatf("reset_hold%0d", i));
      cycle(S_FETCH,    0, 0, RDY, "rtype_fetch");
      cycle(S_DECODE,   0, 0, RDY, "rtype_decode");
      cycle(S_EXECUTER, 0, 0, RDY, "rtype_execr");
      cycle(S_ALUWB,    0, 0, RDY, "rtype_aluwb");
   endtask

   task automatic test_lw;
      op = 7'b0000011;
      cycle(S_FETCH,   0, 1, RDY, "lw_fetch");
      cycle(S_DECODE,  0, 1, RDY, "lw_decode");
      cycle(S_MEMADR,  0, 1, RDY, "lw_memadr");
      cycle(S_MEMREAD, 0, 1, RDY, "lw_memread");
      cycle(S_MEMWB,   0, 1, RDY, "lw_memwb");
   endtask

   task automatic test_sw_itype;
      op = 7'b0100011;
      cycle(S_FETCH,    0, 0, RDY, "sw_fetch");
      cycle(S_DECODE,   0, 0, RDY, "sw_decode");
      cycle(S_MEMADR,   0, 0, RDY, "sw_memadr");
      cycle(S_MEMWRITE, 0, 0, RDY, "sw_memwrite");
      op = 7'b0010011;
      cycle(S_FETCH,    0, 1, RDY, "itype_fetch");
      cycle(S_DECODE,   0, 1, RDY, "itype_decode");
      cycle(S_EXECUTEI, 0, 1, RDY, "itype_execi");
      cycle(S_ALUWB,    0, 1, RDY, "itype_aluwb");
   endtask

   task automatic test_beq;
      op = 7'b1100011;
      cycle(S_FETCH,  0, 1, RDY, "beq_taken_fetch");
      cycle(S_DECODE, 0, 1, RDY, "beq_taken_decode");
      cycle(S_BEQ,    0, 1, RDY, "beq_taken_beq");
      cycle(S_FETCH,  0, 0, RDY, "beq_nt_fetch");
      cycle(S_DECODE, 0, 0, RDY, "beq_nt_decode");
      cycle(S_BEQ,    0, 0, RDY, "beq_nt_beq");
   endtask

   task automatic test_jal;
      op = 7'b1101111;
      cycle(S_FETCH,  0, 0, RDY, "jal_fetch");
      cycle(S_DECODE, 0, 0, RDY, "jal_decode");
      cycle(S_JAL,    0, 1, RDY, "jal_jal");
      cycle(S_ALUWB,  0, 0, RDY, "jal_aluwb");
   endtask

   task automatic test_illegal;
      op = 7'b0000000;
      cycle(S_FETCH,  0, 0, RDY, "ill0_fetch");
      cycle(S_DECODE, 0, 0, RDY, "ill0_decode");
      op = 7'b1111111;
      cycle(S_FETCH,  0, 1, RDY, "ill1_fetch");
      cycle(S_DECODE, 0, 1, RDY, "ill1_decode");
      cycle(S_FETCH,  0, 1, RDY, "ill1_back_to_fetch");
   endtask

   // Reset raised mid-lw, then the instruction is replayed from FETCH.
   task automatic test_reset_abort;
      op = 7'b0000011;
      cycle(S_DECODE,  0, 0, RDY, "abort_decode");
      cycle(S_MEMADR,  0, 0, RDY, "abort_memadr");
      cycle(S_MEMREAD, 1, 0, RDY, "abort_memread_rst");
      cycle(S_FETCH,   1, 0, RDY, "abort_fetch_rst");
      cycle(S_FETCH,   0, 0, RDY, "abort_fetch");
      cycle(S_DECODE,  0, 0, RDY, "abort_redecode");
      cycle(S_MEMADR,  0, 0, RDY, "abort_rememadr");
      cycle(S_MEMREAD, 0, 0, RDY, "abort_rememread");
      cycle(S_MEMWB,   0, 0, RDY, "abort_rememwb");
   endtask

`ifdef MEM_WAIT_EN
   task automatic test_mem_wait;
      op = 7'b0100011;
      cycle(S_FETCH,    0, 0, 0, "wait_fetch0");
      cycle(S_FETCH,    0, 0, 0, "wait_fetch1");
      cycle(S_FETCH,    0, 0, 1, "wait_fetch_rdy");
      cycle(S_DECODE,   0, 0, 0, "wait_decode");
      cycle(S_MEMADR,   0, 0, 0, "wait_memadr");
      for (int i = 0; i < 3; i++) cycle(S_MEMWRITE, 0, 0, 0, $sformatf("wait_memwrite%0d", i));
      cycle(S_MEMWRITE, 0, 0, 1, "wait_memwrite_rdy");
      cycle(S_FETCH,    0, 0, 1, "wait_next_fetch");
   endtask
`endif

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset     = 1'b1;
      op        = 7'b0110011;
      Zero      = 1'b0;
      mem_ready = RDY;
      @(posedge clk);
      #1;
      test_reset();
      test_lw();
      test_sw_itype();
      test_beq();
      test_jal();
      test_illegal();
      test_reset_abort();
`ifdef MEM_WAIT_EN
      test_mem_wait();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
